// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/response bus between the MEM stage and data memory
interface mem_access_unit_if;
  logic        require_mem_access;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_to_mem;
  logic        data_mem_ready_n;
  logic [31:0] data_from_mem;
  modport master (
    output require_mem_access, write, size, addr, data_to_mem,
    input  data_mem_ready_n, data_from_mem
  );
  modport slave (
    input  require_mem_access, write, size, addr, data_to_mem,
    output data_mem_ready_n, data_from_mem
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential RV32I MEM stage with wait-timeout and misalignment detection; define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [31:0]         b,
  input  logic [31:0]         c,
  mem_access_unit_if.master   mem,
  output logic [31:0]         d,
  output logic                stall,
  output logic                done,
  output logic                misaligned,
  output logic                timeout
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, next;
  logic is_load, mem_op, trap, acc, tmo_hit, accept;
  logic load_r, to_r, mis_r;
  logic [2:0] f3_r;
  logic [31:0] b_r, a_r, a_al, ld;
  logic [7:0] byte_s;
  logic [15:0] half_s;
  logic [CNT_W-1:0] cnt;
  assign is_load = opcode == 7'b0000011;
  assign mem_op = valid_in & (is_load | opcode == 7'b0100011);
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op & ((funct3[1:0] == 2'b01 & c[0]) | (funct3[1] & |c[1:0]));
`else
  assign trap = 1'b0;
`endif
  assign a_al = {c[31:2], funct3[1] ? 2'b00 : funct3[0] ? {c[1], 1'b0} : c[1:0]};
  assign acc = state == ACCESS;
  assign accept = state == IDLE & mem_op & !trap;
  assign tmo_hit = TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign byte_s = mem.data_from_mem[{a_r[1:0], 3'b000} +: 8];
  assign half_s = a_r[1] ? mem.data_from_mem[31:16] : mem.data_from_mem[15:0];
  assign ld = f3_r[1] ? mem.data_from_mem
            : f3_r[0] ? {{16{~f3_r[2] & half_s[15]}}, half_s}
            : {{24{~f3_r[2] & byte_s[7]}}, byte_s};
  assign mem.require_mem_access = acc;
  assign mem.write = acc & !load_r;
  assign mem.size = !acc ? 2'b00 : f3_r[1] ? 2'b00 : f3_r[0] ? 2'b01 : 2'b10;
  assign mem.addr = acc ? a_r : '0;
  assign mem.data_to_mem = !acc ? '0 : f3_r[1] ? b_r : f3_r[0] ? {2{b_r[15:0]}} : {4{b_r[7:0]}};
  assign stall = accept | acc;
  assign done = state == DONE;
  assign timeout = to_r;
  assign misaligned = mis_r;
  // next-state selection: ready or timeout ends ACCESS, a trapped access skips it
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = mem_op ? (trap ? DONE : ACCESS) : IDLE;
      ACCESS:  next = (!mem.data_mem_ready_n | tmo_hit) ? DONE : ACCESS;
      default: next = IDLE;
    endcase
  end
  // state, wait counter, latched request, load result and one-cycle flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      d <= '0;
      to_r <= 1'b0;
      mis_r <= 1'b0;
      load_r <= 1'b0;
      f3_r <= '0;
      b_r <= '0;
      a_r <= '0;
    end else begin
      state <= next;
      cnt <= acc ? cnt + 1'b1 : '0;
      to_r <= acc & mem.data_mem_ready_n & tmo_hit;
      mis_r <= state == IDLE & trap;
      if (accept) begin
        load_r <= is_load;
        f3_r <= funct3;
        b_r <= b;
        a_r <= a_al;
      end
      if (acc & !mem.data_mem_ready_n & load_r) d <= ld;
      else if (acc & mem.data_mem_ready_n & tmo_hit) d <= '0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit against a behavioural model
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst, valid_in, stall, done, misaligned, timeout;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [31:0] b, c, d, d_model;
  int checks = 0, errors = 0;
  int o_stalls, o_reqs, o_done_cyc;
  logic o_write, o_to, o_mis, o_stall_done, o_req_done, o_after;
  logic [1:0] o_size;
  logic [31:0] o_addr, o_dtm, o_d;
  mem_access_unit_if bus();
  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .funct3(funct3),
    .b(b), .c(c), .mem(bus.master), .d(d), .stall(stall), .done(done),
    .misaligned(misaligned), .timeout(timeout)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic int unsigned align_of(logic [2:0] f3);
    return f3[1] ? 4 : f3[0] ? 2 : 1;
  endfunction
  function automatic logic [31:0] exp_addr(logic [2:0] f3, logic [31:0] a);
    return a - (a % align_of(f3));
  endfunction
  function automatic logic [1:0] exp_size(logic [2:0] f3);
    return f3[1] ? 2'd0 : f3[0] ? 2'd1 : 2'd2;
  endfunction
  function automatic logic [31:0] exp_dtm(logic [2:0] f3, logic [31:0] v);
    return f3[1] ? v : f3[0] ? (v % 65536) * 32'h00010001 : (v % 256) * 32'h01010101;
  endfunction
  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    longint v;
    int sh = 8 * int'(a % 4);
    case (f3)
      3'd0: begin v = longint'((w >> sh) % 256); if (v >= 128) v = v - 256; end
      3'd4: v = longint'((w >> sh) % 256);
      3'd1: begin v = longint'((w >> sh) % 65536); if (v >= 32768) v = v - 65536; end
      3'd5: v = longint'((w >> sh) % 65536);
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction
  function automatic bit exp_trap(logic [2:0] f3, logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return exp_addr(f3, a) != a;
`else
    return (f3 == 3'd7) && (a == 32'hFFFFFFFF) && 1'b0;
`endif
  endfunction
  task automatic run_op(input bit is_ld, input logic [2:0] f3, input logic [31:0] bv, input logic [31:0] cv,
                        input int waits, input logic [31:0] md);
    valid_in = 1'b1;
    opcode = is_ld ? 7'b0000011 : 7'b0100011;
    funct3 = f3;
    b = bv;
    c = cv;
    bus.data_mem_ready_n = 1'b1;
    bus.data_from_mem = md;
    o_stalls = 0; o_reqs = 0; o_done_cyc = -1;
    o_write = 0; o_size = 0; o_addr = 0; o_dtm = 0; o_d = 0;
    o_to = 0; o_mis = 0; o_stall_done = 1; o_req_done = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (done) begin
        o_done_cyc = i; o_d = d; o_to = timeout; o_mis = misaligned;
        o_stall_done = stall; o_req_done = bus.require_mem_access;
        break;
      end
      if (stall) o_stalls++;
      if (bus.require_mem_access) begin
        o_reqs++;
        if (o_reqs == 1) begin
          o_write = bus.write; o_size = bus.size; o_addr = bus.addr; o_dtm = bus.data_to_mem;
        end
      end
      bus.data_mem_ready_n = !(bus.require_mem_access && o_reqs > waits);
      @(negedge clk);
    end
    valid_in = 1'b0;
    bus.data_mem_ready_n = 1'b1;
    @(negedge clk);
    #1;
    o_after = done | timeout | misaligned;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.require_mem_access, bus.write, bus.size, stall, done, misaligned, timeout} !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0", {bus.require_mem_access, bus.write, bus.size, stall, done, misaligned, timeout});
    end
    checks++;
    if ({bus.addr, bus.data_to_mem, d} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data addr %h dtm %h d %h want 0", bus.addr, bus.data_to_mem, d);
    end
    rst = 1'b0;
    d_model = 32'd0;
  endtask
  task automatic test_lw_basic;
    logic [31:0] md = $urandom;
    run_op(1, 3'd2, 32'h0, 32'h100, 0, md);
    d_model = md;
    checks++;
    if ({o_reqs, o_stalls, o_done_cyc} !== {32'd1, 32'd2, 32'd2}) begin
      errors++;
      $display("FAIL lw_timing reqs %0d stalls %0d done_cyc %0d want 1 2 2", o_reqs, o_stalls, o_done_cyc);
    end
    checks++;
    if ({o_addr, o_size, o_write} !== {32'h100, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL lw_bus addr %h size %0d write %0d want 100 0 0", o_addr, o_size, o_write);
    end
    checks++;
    if (o_d !== md) begin
      errors++;
      $display("FAIL lw_data got %h want %h", o_d, md);
    end
    checks++;
    if ({o_stall_done, o_req_done, o_after} !== 3'b000) begin
      errors++;
      $display("FAIL lw_done_cycle stall %0d req %0d pulse_after %0d want 0 0 0", o_stall_done, o_req_done, o_after);
    end
  endtask
  task automatic test_sb_wait;
    run_op(0, 3'd0, 32'h000000A5, 32'h203, 3, 32'h0);
    checks++;
    if ({o_dtm, o_size, o_write, o_addr} !== {32'hA5A5A5A5, 2'd2, 1'b1, 32'h203}) begin
      errors++;
      $display("FAIL sb_bus dtm %h size %0d write %0d addr %h want a5a5a5a5 2 1 203", o_dtm, o_size, o_write, o_addr);
    end
    checks++;
    if ({o_stalls, o_reqs} !== {32'd5, 32'd4}) begin
      errors++;
      $display("FAIL sb_stalls stalls %0d reqs %0d want 5 4", o_stalls, o_reqs);
    end
    checks++;
    if (o_d !== d_model) begin
      errors++;
      $display("FAIL sb_d_hold got %h want %h", o_d, d_model);
    end
  endtask
  task automatic test_lb_lbu;
    run_op(1, 3'd0, 32'h0, 32'h3, 0, 32'h80FF0000);
    d_model = 32'hFFFFFF80;
    checks++;
    if (o_d !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_sign got %h want ffffff80", o_d);
    end
    run_op(1, 3'd4, 32'h0, 32'h3, 1, 32'h80FF0000);
    d_model = 32'h00000080;
    checks++;
    if (o_d !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu_zero got %h want 00000080", o_d);
    end
  endtask
  task automatic test_non_mem;
    logic [6:0] ops [3] = '{7'b0110011, 7'b0010011, 7'b1100011};
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      opcode = ops[i];
      c = $urandom;
      @(negedge clk);
      #1;
      checks++;
      if ({stall, bus.require_mem_access, done} !== 3'b000) begin
        errors++;
        $display("FAIL non_mem op %b stall %0d req %0d done %0d want 0 0 0", ops[i], stall, bus.require_mem_access, done);
      end
    end
    valid_in = 1'b0;
    opcode = 7'b0000011;
    @(negedge clk);
    #1;
    checks++;
    if ({stall, bus.require_mem_access} !== 2'b00) begin
      errors++;
      $display("FAIL invalid_load stall %0d req %0d want 0 0", stall, bus.require_mem_access);
    end
  endtask
  task automatic test_timeout;
    run_op(1, 3'd2, 32'h0, 32'h40, 0, 32'hDEADBEEF);
    d_model = 32'hDEADBEEF;
    run_op(1, 3'd2, 32'h0, 32'h80, 1000, 32'h12345678);
    d_model = 32'd0;
    checks++;
    if ({o_reqs, o_stalls, o_done_cyc} !== {32'd4, 32'd5, 32'd5}) begin
      errors++;
      $display("FAIL timeout_timing reqs %0d stalls %0d done_cyc %0d want 4 5 5", o_reqs, o_stalls, o_done_cyc);
    end
    checks++;
    if ({o_to, o_req_done, o_after} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_flags to %0d req %0d pulse_after %0d want 1 0 0", o_to, o_req_done, o_after);
    end
    checks++;
    if (o_d !== 32'd0) begin
      errors++;
      $display("FAIL timeout_d got %h want 0", o_d);
    end
  endtask
  task automatic test_misaligned;
    run_op(1, 3'd1, 32'h0, 32'h101, 0, 32'hCAFE8001);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if ({o_mis, o_reqs, o_stalls, o_done_cyc} !== {1'b1, 32'd0, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL lh_trap mis %0d reqs %0d stalls %0d done_cyc %0d want 1 0 0 1", o_mis, o_reqs, o_stalls, o_done_cyc);
    end
`else
    d_model = 32'hFFFF8001;
    checks++;
    if ({o_mis, o_addr, o_reqs, o_stalls} !== {1'b0, 32'h100, 32'd1, 32'd2}) begin
      errors++;
      $display("FAIL lh_align mis %0d addr %h reqs %0d stalls %0d want 0 100 1 2", o_mis, o_addr, o_reqs, o_stalls);
    end
`endif
    checks++;
    if (o_d !== d_model) begin
      errors++;
      $display("FAIL lh_misaligned_d got %h want %h", o_d, d_model);
    end
  endtask
  task automatic test_random;
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 60; n++) begin
      bit is_ld = 1'($urandom_range(0, 1));
      logic [2:0] f3 = is_ld ? ld_f3[$urandom_range(0, 4)] : ld_f3[$urandom_range(0, 2)];
      logic [31:0] cv = $urandom;
      logic [31:0] bv = $urandom;
      logic [31:0] md = $urandom;
      int waits = $urandom_range(0, 3);
      bit tr;
      if ($urandom_range(0, 1) == 1) cv = exp_addr(f3, cv);
      tr = exp_trap(f3, cv);
      run_op(is_ld, f3, bv, cv, waits, md);
      if (tr) begin
        checks++;
        if ({o_mis, o_reqs, o_stalls, o_done_cyc} !== {1'b1, 32'd0, 32'd0, 32'd1}) begin
          errors++;
          $display("FAIL rnd_trap[%0d] mis %0d reqs %0d stalls %0d done_cyc %0d want 1 0 0 1", n, o_mis, o_reqs, o_stalls, o_done_cyc);
        end
      end else begin
        if (is_ld) d_model = exp_load(f3, exp_addr(f3, cv), md);
        checks++;
        if ({o_reqs, o_stalls, o_done_cyc} !== {waits + 1, waits + 2, waits + 2}) begin
          errors++;
          $display("FAIL rnd_timing[%0d] reqs %0d stalls %0d done_cyc %0d want %0d %0d %0d", n, o_reqs, o_stalls, o_done_cyc, waits + 1, waits + 2, waits + 2);
        end
        checks++;
        if ({o_addr, o_size, o_write, is_ld ? 32'd0 : o_dtm} !== {exp_addr(f3, cv), exp_size(f3), !is_ld, is_ld ? 32'd0 : exp_dtm(f3, bv)}) begin
          errors++;
          $display("FAIL rnd_bus[%0d] addr %h size %0d write %0d dtm %h want %h %0d %0d %h", n, o_addr, o_size, o_write, o_dtm, exp_addr(f3, cv), exp_size(f3), !is_ld, exp_dtm(f3, bv));
        end
        checks++;
        if (o_mis !== 1'b0) begin
          errors++;
          $display("FAIL rnd_mis[%0d] got %0d want 0", n, o_mis);
        end
      end
      checks++;
      if (o_d !== d_model) begin
        errors++;
        $display("FAIL rnd_d[%0d] f3 %0d c %h got %h want %h", n, f3, cv, o_d, d_model);
      end
      checks++;
      if ({o_to, o_stall_done, o_req_done, o_after} !== 4'b0000) begin
        errors++;
        $display("FAIL rnd_flags[%0d] to %0d stall %0d req %0d pulse_after %0d want 0 0 0 0", n, o_to, o_stall_done, o_req_done, o_after);
      end
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] md = $urandom;
    valid_in = 1'b1;
    opcode = 7'b0000011;
    funct3 = 3'd2;
    c = 32'h40;
    bus.data_mem_ready_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.require_mem_access !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_access req %0d want 1", bus.require_mem_access);
    end
    rst = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    #1;
    d_model = 32'd0;
    checks++;
    if ({bus.require_mem_access, bus.write, bus.size, stall, done, misaligned, timeout, bus.addr, d} !== 72'd0) begin
      errors++;
      $display("FAIL mid_reset req %0d stall %0d done %0d addr %h d %h want all 0", bus.require_mem_access, stall, done, bus.addr, d);
    end
    rst = 1'b0;
    run_op(1, 3'd2, 32'h0, 32'h44, 1, md);
    d_model = md;
    checks++;
    if ({o_d, o_reqs, o_stalls} !== {md, 32'd2, 32'd3}) begin
      errors++;
      $display("FAIL post_reset_lw d %h reqs %0d stalls %0d want %h 2 3", o_d, o_reqs, o_stalls, md);
    end
  endtask
  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    opcode = '0;
    funct3 = '0;
    b = '0;
    c = '0;
    bus.data_mem_ready_n = 1'b1;
    bus.data_from_mem = '0;
    d_model = '0;
    @(negedge clk);
    test_reset;
    test_lw_basic;
    test_sb_wait;
    test_lb_lbu;
    test_non_mem;
    test_timeout;
    test_misaligned;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
